fpcvt_scheduler: RTL

Shares one `fpcvt` 12-bit two's-complement to floating-point converter between `NREQ` requesters. A round-robin arbiter admits one request at a time over a valid/ready handshake and registers the operand. The shared converter evaluates it, and the block registers the result (S, E, F) with the originating requester ID and presents it on a single output channel with backpressure. It sits between the sample sources and the downstream consumer of the floating-point words.

---
 rtl/fpcvt_pkg.sv | 32 +++
 rtl/fpcvt.sv | 48 ++++
 rtl/rr_arbiter.sv | 34 +++
 rtl/fpcvt_scheduler.sv | 152 +++++++++++++++
 4 files changed

// File: rtl/fpcvt_pkg.sv
// Shared widths, FSM state encoding, saturation constants and the
// magnitude helper used by the fpcvt datapath and its scheduler.
package fpcvt_pkg;

   localparam int D_W = 12;
   localparam int E_W = 3;
   localparam int F_W = 4;

   localparam logic [E_W-1:0] E_SAT      = 3'd7;
   localparam logic [F_W-1:0] F_SAT      = 4'd15;
   localparam logic [F_W-1:0] F_RND_WRAP = 4'd8;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      CONV = 2'd1,
      HOLD = 2'd2
   } state_e;

   // -2048 has no positive counterpart in 12 bits, so it clamps to 2047
   function automatic logic [D_W-2:0] abs_sat(input logic [D_W-1:0] d);
      logic [D_W-1:0] neg;
      neg = (~d) + 12'd1;
      if (!d[D_W-1]) begin
         abs_sat = d[D_W-2:0];
      end else if (d == 12'h800) begin
         abs_sat = 11'h7FF;
      end else begin
         abs_sat = neg[D_W-2:0];
      end
   endfunction

endpackage

// File: rtl/fpcvt.sv
// Combinational 12-bit two's-complement to (S, E, F) converter:
// value ~= F * 2^E, F rounded half-up on the first dropped bit.
module fpcvt
   import fpcvt_pkg::*;
(
   input  logic [D_W-1:0] d_i,
   output logic           s_o,
   output logic [E_W-1:0] e_o,
   output logic [F_W-1:0] f_o
);

   logic [D_W-2:0] mag_s;
   logic [E_W-1:0] e_raw_s;
   logic [F_W:0]   sh_s;
   logic [F_W:0]   f_sum_s;

   assign mag_s = abs_sat(d_i);

   // exponent = how far the leading one sits above the 4-bit significand
   always_comb begin
      e_raw_s = '0;
      for (int i = F_W; i < D_W - 1; i++) begin
         e_raw_s = mag_s[i] ? E_W'(i - F_W + 1) : e_raw_s;
      end
   end

   // appended zero makes the round bit vanish when nothing is shifted out
   assign sh_s    = 5'({mag_s, 1'b0} >> e_raw_s);
   assign f_sum_s = {1'b0, sh_s[F_W:1]} + {{F_W{1'b0}}, sh_s[0]};

   // rounding carry renormalises to 1000 or saturates at the top exponent
   always_comb begin
      s_o = d_i[D_W-1];
      if (f_sum_s[F_W]) begin
         if (e_raw_s == E_SAT) begin
            e_o = E_SAT;
            f_o = F_SAT;
         end else begin
            e_o = e_raw_s + 3'd1;
            f_o = F_RND_WRAP;
         end
      end else begin
         e_o = e_raw_s;
         f_o = f_sum_s[F_W-1:0];
      end
   end

endmodule

// File: rtl/rr_arbiter.sv
// Round-robin arbiter: search starts one past the last grant, first
// asserted request wins; nothing is granted while en_i is low.
module rr_arbiter #(
   parameter int NREQ = 4,
   parameter int IDW  = $clog2(NREQ)
) (
   input  logic [NREQ-1:0] req_i,
   input  logic [IDW-1:0]  last_grant_i,
   input  logic            en_i,
   output logic [NREQ-1:0] grant_o,
   output logic [IDW-1:0]  idx_o
);

   logic           found_s;
   logic           hit_s;
   logic [IDW-1:0] pos_s;

   // rotating priority scan, first hit latches
   always_comb begin
      grant_o = '0;
      idx_o   = '0;
      found_s = 1'b0;
      hit_s   = 1'b0;
      pos_s   = '0;
      for (int k = 1; k <= NREQ; k++) begin
         pos_s          = IDW'((int'(last_grant_i) + k) % NREQ);
         hit_s          = en_i & ~found_s & req_i[pos_s];
         grant_o[pos_s] = grant_o[pos_s] | hit_s;
         idx_o          = hit_s ? pos_s : idx_o;
         found_s        = found_s | hit_s;
      end
   end

endmodule

// File: rtl/fpcvt_scheduler.sv
// Shares one fpcvt converter between NREQ requesters: round-robin admit,
// one-cycle conversion, registered result held until the consumer takes it.
module fpcvt_scheduler
   import fpcvt_pkg::*;
#(
   parameter int NREQ = 4,
   parameter int IDW  = $clog2(NREQ)
) (
   input  logic                clk_i,
   input  logic                rst_ni,
   input  logic [NREQ-1:0]     req_valid_i,
   input  logic [D_W*NREQ-1:0] req_data_i,
   output logic [NREQ-1:0]     req_ready_o,
   output logic                out_valid_o,
   input  logic                out_ready_i,
   output logic                out_s_o,
   output logic [E_W-1:0]      out_e_o,
   output logic [F_W-1:0]      out_f_o,
   output logic [IDW-1:0]      out_id_o,
   output logic                busy_o,
   output logic [15:0]         conv_count_o
);

   logic [1:0]     rst_sync_q;
   logic           run_s;
   state_e         state_q;
   logic [D_W-1:0] opnd_q;
   logic [IDW-1:0] id_q;
   logic [IDW-1:0] last_grant_q;
   logic           out_valid_q;
   logic           out_s_q;
   logic [E_W-1:0] out_e_q;
   logic [F_W-1:0] out_f_q;
   logic [IDW-1:0] out_id_q;
   logic           busy_q;
   logic [15:0]    conv_count_q;

   logic           accept_en_s;
   logic           accept_s;
   logic [NREQ-1:0] grant_s;
   logic [IDW-1:0] gidx_s;
   logic [D_W-1:0] sel_data_s;
   logic           cvt_s_s;
   logic [E_W-1:0] cvt_e_s;
   logic [F_W-1:0] cvt_f_s;

   // reset asserts asynchronously; admission resumes two clean edges later
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         rst_sync_q <= 2'b00;
      end else begin
         rst_sync_q <= {rst_sync_q[0], 1'b1};
      end
   end

   assign run_s       = rst_sync_q[1];
   assign accept_en_s = run_s & ((state_q == IDLE) | ((state_q == HOLD) & out_ready_i));
   assign accept_s    = |grant_s;
   assign sel_data_s  = req_data_i[gidx_s*D_W +: D_W];
   assign req_ready_o = grant_s;

   rr_arbiter #(
      .NREQ (NREQ),
      .IDW  (IDW)
   ) u_arb (
      .req_i        (req_valid_i),
      .last_grant_i (last_grant_q),
      .en_i         (accept_en_s),
      .grant_o      (grant_s),
      .idx_o        (gidx_s)
   );

   fpcvt u_cvt (
      .d_i (opnd_q),
      .s_o (cvt_s_s),
      .e_o (cvt_e_s),
      .f_o (cvt_f_s)
   );

   // scheduler FSM with operand, result, status and counter registers
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         state_q      <= IDLE;
         opnd_q       <= '0;
         id_q         <= '0;
         last_grant_q <= IDW'(NREQ - 1);
         out_valid_q  <= 1'b0;
         out_s_q      <= 1'b0;
         out_e_q      <= '0;
         out_f_q      <= '0;
         out_id_q     <= '0;
         busy_q       <= 1'b0;
         conv_count_q <= 16'd0;
      end else begin
         case (state_q)
            IDLE: begin
               if (accept_s) begin
                  opnd_q       <= sel_data_s;
                  id_q         <= gidx_s;
                  last_grant_q <= gidx_s;
                  busy_q       <= 1'b1;
                  state_q      <= CONV;
               end else begin
                  busy_q  <= 1'b0;
                  state_q <= IDLE;
               end
            end
            CONV: begin
               out_valid_q <= 1'b1;
               out_s_q     <= cvt_s_s;
               out_e_q     <= cvt_e_s;
               out_f_q     <= cvt_f_s;
               out_id_q    <= id_q;
               busy_q      <= 1'b1;
               state_q     <= HOLD;
            end
            HOLD: begin
               if (out_ready_i) begin
                  out_valid_q  <= 1'b0;
                  conv_count_q <= conv_count_q + 16'd1;
                  if (accept_s) begin
                     opnd_q       <= sel_data_s;
                     id_q         <= gidx_s;
                     last_grant_q <= gidx_s;
                     busy_q       <= 1'b1;
                     state_q      <= CONV;
                  end else begin
                     busy_q  <= 1'b0;
                     state_q <= IDLE;
                  end
               end else begin
                  state_q <= HOLD;
               end
            end
            default: begin
               out_valid_q <= 1'b0;
               busy_q      <= 1'b0;
               state_q     <= IDLE;
            end
         endcase
      end
   end

   assign out_valid_o  = out_valid_q;
   assign out_s_o      = out_s_q;
   assign out_e_o      = out_e_q;
   assign out_f_o      = out_f_q;
   assign out_id_o     = out_id_q;
   assign busy_o       = busy_q;
   assign conv_count_o = conv_count_q;

endmodule
